// File: rtl/intdump_pkg.sv
// Shared definitions for the integrate-and-dump controller: FSM encoding,
// accumulator width derivation and saturation limits.
package intdump_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   function automatic int acc_width(input int w, input int gw);
      return w + gw;
   endfunction

   function automatic logic signed [63:0] sat_max(input int aw);
      return (64'sd1 <<< (aw - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] sat_min(input int aw);
      return -(64'sd1 <<< (aw - 1));
   endfunction

endpackage

// File: rtl/intdump_acc.sv
// Accumulate/clear datapath. With INTDUMP_SAT_EN defined the add saturates
// and flags sat_hit; otherwise it wraps two's-complement.
module intdump_acc
   import intdump_pkg::*;
#(
   parameter int W  = 10,
   parameter int GW = 4,
   localparam int AW = acc_width(W, GW)
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 add_en,
   input  logic                 clr,
   input  logic signed [W-1:0]  din,
   output logic signed [AW-1:0] sum_next,
   output logic                 sat_hit
);

   logic signed [AW-1:0] acc_q;
   logic signed [AW:0]   wide;

   // One extra bit exposes overflow as a disagreement of the top two bits.
   assign wide = {acc_q[AW-1], acc_q} + (AW+1)'(din);

`ifdef INTDUMP_SAT_EN
   localparam logic signed [AW-1:0] SMAX = AW'(sat_max(AW));
   localparam logic signed [AW-1:0] SMIN = AW'(sat_min(AW));

   always_comb begin
      sat_hit  = 1'b0;
      sum_next = wide[AW-1:0];
      if (wide[AW] != wide[AW-1]) begin
         sat_hit  = 1'b1;
         sum_next = wide[AW] ? SMIN : SMAX;
      end
   end
`else
   assign sum_next = wide[AW-1:0];
   assign sat_hit  = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)       acc_q <= '0;
      else if (clr)    acc_q <= '0;
      else if (add_en) acc_q <= sum_next;
   end

endmodule

// File: rtl/intdump_ctrl.sv
// Integrate-and-dump controller: frame counting, dump, back-pressure, abort.
// Optional saturation and sticky ovf are enabled by INTDUMP_SAT_EN.
module intdump_ctrl
   import intdump_pkg::*;
#(
   parameter int W  = 10,
   parameter int GW = 4,
   parameter int LW = 8,
   localparam int AW = acc_width(W, GW)
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 en,
   input  logic [LW-1:0]        len,
   input  logic                 din_vld,
   input  logic signed [W-1:0]  din,
   output logic                 din_rdy,
   output logic                 dout_vld,
   output logic signed [AW-1:0] dout,
   input  logic                 dout_rdy,
   output logic                 busy,
   output logic                 ovf
);

   // Valid/ready: a transfer happens on a rising clk edge when both valid and
   // ready are high; ready may depend on valid-independent state only.
   state_t               state_q, state_d;
   logic [LW-1:0]        cnt_q, cnt_d;
   logic [LW-1:0]        len_q, len_d;
   logic signed [AW-1:0] dout_q;
   logic                 dout_vld_q;
   logic                 add_en, clr, dump;
   logic signed [AW-1:0] sum_next;
   logic                 sat_hit;
   logic [LW-1:0]        len_eff;
   logic                 last, out_blocked, out_xfer;

   assign len_eff     = (len == '0) ? LW'(1) : len;
   assign last        = (cnt_q == len_q - LW'(1));
   assign out_blocked = dout_vld_q & ~dout_rdy;
   assign out_xfer    = dout_vld_q & dout_rdy;

   intdump_acc #(.W(W), .GW(GW)) u_acc (
      .clk      (clk),
      .rstn     (rstn),
      .add_en   (add_en),
      .clr      (clr),
      .din      (din),
      .sum_next (sum_next),
      .sat_hit  (sat_hit)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      add_en  = 1'b0;
      clr     = 1'b0;
      dump    = 1'b0;
      din_rdy = 1'b0;
      case (state_q)
         IDLE: begin
            clr = 1'b1;
            if (en) begin
               state_d = RUN;
               len_d   = len_eff;
            end
         end
         RUN: begin
            if (!en) begin
               clr     = 1'b1;
               cnt_d   = '0;
               state_d = out_blocked ? FLUSH : IDLE;
            end else begin
               // Closing a frame needs a free (or draining) output register.
               din_rdy = !(last && out_blocked);
               if (din_vld && din_rdy) begin
                  if (last) begin
                     dump  = 1'b1;
                     clr   = 1'b1;
                     cnt_d = '0;
                     len_d = len_eff;
                  end else begin
                     add_en = 1'b1;
                     cnt_d  = cnt_q + LW'(1);
                  end
               end
            end
         end
         FLUSH: begin
            clr = 1'b1;
            if (out_xfer) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         len_q      <= LW'(1);
         dout_q     <= '0;
         dout_vld_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         if (dump) begin
            dout_q     <= sum_next;
            dout_vld_q <= 1'b1;
         end else if (out_xfer) begin
            dout_vld_q <= 1'b0;
         end
      end
   end

`ifdef INTDUMP_SAT_EN
   logic en_q, ovf_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         en_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         en_q  <= en;
         ovf_q <= (ovf_q && !(en && !en_q)) || (sat_hit && (add_en || dump));
      end
   end

   assign ovf = ovf_q;
`else
   // sat_hit is constant 0 when saturation is compiled out.
   assign ovf = sat_hit;
`endif

   assign dout_vld = dout_vld_q;
   assign dout     = dout_q;
   assign busy     = (cnt_q != '0);

endmodule

// File: tb/tb_intdump_ctrl.sv
// Self-checking bench for intdump_ctrl: directed scenarios plus random traffic
// compared against a frame-level reference model with an expected-dump queue.
module tb_intdump_ctrl;

   localparam int W  = 10;
   localparam int GW = 4;
   localparam int LW = 8;
   localparam int AW = W + GW;
   localparam longint SMAX = (64'sd1 <<< (AW - 1)) - 1;
   localparam longint SMIN = -(64'sd1 <<< (AW - 1));

   logic                 clk, rstn, en, din_vld, dout_rdy;
   logic [LW-1:0]        len;
   logic signed [W-1:0]  din;
   logic                 din_rdy, dout_vld, busy, ovf;
   logic signed [AW-1:0] dout;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [AW-1:0] exp_q[$];
   int            m_mode;
   int            m_cnt;
   int            m_len;
   longint        m_sum;
   bit            m_ovf;
   bit            m_prev_en;

   intdump_ctrl #(.W(W), .GW(GW), .LW(LW)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .en       (en),
      .len      (len),
      .din_vld  (din_vld),
      .din      (din),
      .din_rdy  (din_rdy),
      .dout_vld (dout_vld),
      .dout     (dout),
      .dout_rdy (dout_rdy),
      .busy     (busy),
      .ovf      (ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_mode    = 0;
      m_cnt     = 0;
      m_len     = 1;
      m_sum     = 0;
      m_ovf     = 1'b0;
      m_prev_en = 1'b0;
   endtask

   // Checks the DUT outputs for this cycle, then advances the model across the edge.
   task automatic model();
      bit     pend, out_x, in_x, exp_rdy;
      longint s;
      pend    = exp_q.size() != 0;
      out_x   = pend && dout_rdy;
      exp_rdy = (m_mode == 1) && en && !((m_cnt == m_len - 1) && pend && !dout_rdy);
      in_x    = din_vld && exp_rdy;
      chk("din_rdy", AW'(din_rdy), AW'(exp_rdy));
      chk("dout_vld", AW'(dout_vld), AW'(pend));
      chk("busy", AW'(busy), AW'(m_cnt != 0));
      chk("ovf", AW'(ovf), AW'(m_ovf));
      if (pend) chk("dout", dout, exp_q[0]);
      if (en && !m_prev_en) m_ovf = 1'b0;
      m_prev_en = en;
      if (out_x) void'(exp_q.pop_front());
      case (m_mode)
         0: if (en) begin
            m_mode = 1;
            m_len  = (len == 0) ? 1 : int'(len);
            m_cnt  = 0;
            m_sum  = 0;
         end
         1: if (!en) begin
            m_mode = (pend && !dout_rdy) ? 2 : 0;
            m_cnt  = 0;
            m_sum  = 0;
         end else if (in_x) begin
            s = m_sum + longint'(din);
`ifdef INTDUMP_SAT_EN
            if (s > SMAX) begin s = SMAX; m_ovf = 1'b1; end
            else if (s < SMIN) begin s = SMIN; m_ovf = 1'b1; end
`endif
            if (m_cnt == m_len - 1) begin
               exp_q.push_back(AW'(s));
               m_cnt = 0;
               m_sum = 0;
               m_len = (len == 0) ? 1 : int'(len);
            end else begin
               m_cnt++;
               m_sum = s;
            end
         end
         default: if (out_x) m_mode = 0;
      endcase
   endtask

   // Called at a falling edge; drives one cycle and returns at the next falling edge.
   task automatic step(input bit e, input int l, input bit v, input int d, input bit r);
      en       = e;
      len      = LW'(l);
      din_vld  = v;
      din      = W'(d);
      dout_rdy = r;
      #1;
      model();
      @(negedge clk);
   endtask

   task automatic go_idle();
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
   endtask

   initial begin
      int d;
      rstn = 1'b1; en = 1'b0; len = '0; din_vld = 1'b0; din = '0; dout_rdy = 1'b0;
      model_reset();
      #3 rstn = 1'b0;
      #1;
      chk("rst_din_rdy", AW'(din_rdy), '0);
      chk("rst_dout_vld", AW'(dout_vld), '0);
      chk("rst_dout", dout, '0);
      chk("rst_busy", AW'(busy), '0);
      chk("rst_ovf", AW'(ovf), '0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      // frame of 1..4, then a second frame from a clean accumulator
      step(1, 4, 0, 0, 1);
      for (int i = 1; i <= 4; i++) step(1, 4, 1, i, 0);
      chk("t1_vld", AW'(dout_vld), AW'(1));
      chk("t1_dout", dout, AW'(10));
      for (int i = 0; i < 4; i++) step(1, 4, 1, 5, 1);
      chk("t1_dout2", dout, AW'(20));
      go_idle();

      // back-pressure stalls the closing sample of the next frame
      step(1, 3, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 3, 1, -5, 0);
      chk("t2_dout", dout, AW'(-15));
      step(1, 3, 1, 7, 0);
      step(1, 3, 1, 7, 0);
      chk("t2_stall", AW'(din_rdy), '0);
      step(1, 3, 1, 7, 0);
      chk("t2_hold", dout, AW'(-15));
      step(1, 3, 1, 7, 1);
      chk("t2_dout2", dout, AW'(21));
      go_idle();

      // abort mid-frame with an undrained result -> flush
      step(1, 2, 0, 0, 0);
      step(1, 2, 1, 20, 0);
      step(1, 8, 1, 22, 0);
      for (int i = 0; i < 5; i++) step(1, 8, 1, 1, 0);
      step(0, 8, 1, 1, 0);
      chk("t3_dout", dout, AW'(42));
      chk("t3_busy", AW'(busy), '0);
      step(1, 8, 1, 1, 0);
      step(1, 8, 1, 1, 0);
      chk("t3_flush_vld", AW'(dout_vld), AW'(1));
      step(1, 8, 0, 0, 1);
      chk("t3_drained", AW'(dout_vld), '0);
      go_idle();

      // len=0 acts as 1
      step(1, 0, 0, 0, 1);
      step(1, 0, 1, 9, 1);
      chk("t4_dout_a", dout, AW'(9));
      step(1, 0, 1, -2, 1);
      chk("t4_dout_b", dout, AW'(-2));
      go_idle();

      // len change mid-frame applies at the next frame
      step(1, 4, 0, 0, 1);
      step(1, 4, 1, 1, 1);
      step(1, 4, 1, 2, 1);
      step(1, 2, 1, 3, 1);
      step(1, 2, 1, 4, 1);
      chk("t5_dout_a", dout, AW'(10));
      step(1, 2, 1, 5, 1);
      step(1, 2, 1, 6, 1);
      chk("t5_dout_b", dout, AW'(11));
      go_idle();

      // large positive sum: saturates or wraps depending on build
      step(1, 20, 0, 0, 1);
      for (int i = 0; i < 20; i++) step(1, 20, 1, 511, 1);
`ifdef INTDUMP_SAT_EN
      chk("t6_dout", dout, AW'(8191));
      chk("t6_ovf", AW'(ovf), AW'(1));
`else
      chk("t6_dout", dout, AW'(-6164));
      chk("t6_ovf", AW'(ovf), '0);
`endif
      for (int i = 0; i < 20; i++) step(1, 20, 1, 1, 1);
      go_idle();

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 3) == 0) d = ($urandom_range(0, 1) == 1) ? 511 : -512;
         else d = int'($urandom_range(0, 1023)) - 512;
         step($urandom_range(0, 99) < 97,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 6)),
              $urandom_range(0, 9) < 8, d, $urandom_range(0, 9) < 6);
      end
      go_idle();

      // asynchronous reset mid-frame with a pending result
      step(1, 1, 0, 0, 0);
      step(1, 4, 1, 5, 0);
      step(1, 4, 1, 3, 0);
      step(1, 4, 1, 3, 0);
      #2 rstn = 1'b0;
      #1;
      chk("ar_din_rdy", AW'(din_rdy), '0);
      chk("ar_dout_vld", AW'(dout_vld), '0);
      chk("ar_dout", dout, '0);
      chk("ar_busy", AW'(busy), '0);
      chk("ar_ovf", AW'(ovf), '0);
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
      step(1, 2, 0, 0, 1);
      step(1, 2, 1, 6, 1);
      step(1, 2, 1, 7, 1);
      chk("ar_after", dout, AW'(13));
      go_idle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/intdump_ctrl.md
Name: intdump_ctrl

Overview:
Integrate-and-dump controller. Accumulates a programmable number of signed input samples, presents the sum on a valid/ready output, clears, and repeats. It sequences the shared accumulator datapath: frame counting, dump timing, back-pressure and abort. It sits between the decimating front end and the downstream detector/slicer.

Parameters:
W, 10, input sample width (signed)
GW, 4, accumulator guard bits; accumulator/output width AW = W+GW
LW, 8, frame-length register width

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
en  in  1  run enable; level-sensitive
len  in  LW  samples per frame (N); 0 treated as 1
din_vld  in  1  input sample valid
din  in  W  signed input sample
din_rdy  out  1  controller accepts din this cycle
dout_vld  out  1  dump result valid
dout  out  AW  signed frame sum
dout_rdy  in  1  downstream accepts dout
busy  out  1  frame in progress (cnt != 0)
ovf  out  1  sticky overflow flag (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk. Reset rstn is asynchronous, active-low. All state is cleared on reset assertion.
- Reset values: din_rdy=0, dout_vld=0, dout=0, busy=0, ovf=0, acc=0, cnt=0, state=IDLE.
- Input transfer: din_vld & din_rdy. Output transfer: dout_vld & dout_rdy.
- State IDLE:
  - din_rdy=0; acc=0, cnt=0.
  - en=1 -> RUN. len is latched into len_q on that edge, with 0 mapped to 1.
- State RUN, din_rdy:
  - din_rdy = 1, except when the next accepted sample is the last one (cnt==len_q-1) and the output register is occupied and not draining (dout_vld & !dout_rdy). In that case din_rdy=0, which stalls the input.
- State RUN, non-last transfer: acc <= acc + sext(din); cnt <= cnt+1.
- State RUN, last transfer (cnt==len_q-1):
  - dout <= acc + sext(din); dout_vld <= 1.
  - acc <= 0; cnt <= 0.
  - len_q <= current len (0 -> 1).
  - Latency: dout_vld rises one cycle after the last input transfer.
- Throughput: one sample per cycle sustained when dout_rdy=1. A dump and the first sample of the next frame never share a cycle, because the last sample closes the frame.
- Output register: holds dout/dout_vld until an output transfer. If an output transfer and a new dump occur in the same cycle, the new result is loaded and dout_vld stays 1.
- len changes mid-frame: ignored until the next frame boundary.
- en deasserted in RUN:
  - The partial frame is discarded: acc=0, cnt=0, no dump.
  - Go to FLUSH if dout_vld & !dout_rdy, else go to IDLE.
  - A sample presented in the same cycle is not accepted (din_rdy=0 once en=0).
- State FLUSH:
  - din_rdy=0.
  - Stay until an output transfer, then -> IDLE.
  - en reasserted in FLUSH is honoured only after reaching IDLE.
- busy = (cnt != 0).
- Width: din is sign-extended to AW. Without saturation, sums wrap modulo 2^AW. Overflow-free is guaranteed for N <= 2^GW.
- Reset mid-frame: immediate clear of everything, including a pending dout.

Optional Feature:
Macro INTDUMP_SAT_EN.
- Defined: accumulation (including the final dump add) saturates to +(2^(AW-1)-1) or -2^(AW-1). ovf is set on any saturation event and is sticky until rstn or a rising edge of en.
- Undefined: sums wrap two's-complement and ovf is tied to 0.

Decomposition:
- Shared package intdump_pkg holds:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, FLUSH=2'd2);
  - the AW derivation;
  - the saturation limit constants.
- One natural sub-module: intdump_acc. It is the accumulate/clear/saturate datapath, with inputs add_en, clr, din and outputs sum_next, sat_hit. The FSM, counter and handshake stay in the top level.

Test Plan:
1. W=10, len=4, en=1, din=1,2,3,4 back-to-back, dout_rdy=1 -> dout_vld one cycle after the 4th sample, dout=10; busy high for 3 cycles; the next frame starts with acc=0.
2. len=3, din=-5,-5,-5, then dout_rdy held 0 through the next frame -> dout=-15 held. din_rdy drops exactly on the 3rd sample of frame 2. After dout_rdy=1, frame 2 (din=7,7,7) yields 21.
3. len=8, en dropped after 5 samples -> no dump, acc/cnt cleared, IDLE. A pending unaccepted dout=42 goes to FLUSH and releases on dout_rdy, then IDLE.
4. len=0, din=9,-2 -> two dumps: 9 then -2 (len 0 treated as 1).
5. Change len 4->2 after the 2nd sample of a 4-sample frame -> current frame dumps after 4 samples; the next frame dumps after 2.
6. INTDUMP_SAT_EN defined, GW=0, W=10, len=4, din=511 x4 -> dout=511, ovf=1 sticky. Undefined: dout=-4 (wrap), ovf=0. Assert rstn=0 mid-frame -> all outputs 0 asynchronously.
